// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched
// Purpose  : Time-shares one 4x4 unsigned multiplier (Mult_Wallace4) among
//            NUM_REQ requesters. Each granted 8x8 multiply is built from four
//            nibble partial products accumulated over four cycles. The
//            16-bit product and the requester ID are returned on a
//            valid/ready response port.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            req_valid/ready - per-requester handshake (one ready bit max)
//            req_a/req_b     - packed 8-bit operands, requester i at [8i+7:8i]
//            rsp_valid/ready - response handshake
//            rsp_id/rsp_prod - owner ID and 16-bit product
//            busy            - high whenever the scheduler is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_prod,
    output logic                 busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [ID_W-1:0] r_ptr;
    logic [1:0]      r_step;
    logic [15:0]     r_acc;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [ID_W-1:0] r_id;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [15:0]     r_rsp_prod;

    logic            w_any;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_ptr_next;
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [3:0]      w_nib_a;
    logic [3:0]      w_nib_b;
    logic [7:0]      w_pp;
    logic [15:0]     w_pp_shifted;
    logic [15:0]     w_acc_next;

    // Round-robin search starting at r_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int w_idx;
        w_idx   = 0;
        w_any   = 1'b0;
        w_grant = '0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any && req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = ID_W'(w_idx);
                w_a     = req_a[w_idx*8 +: 8];
                w_b     = req_b[w_idx*8 +: 8];
            end
        end
    end

    assign w_ptr_next = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + ID_W'(1);

    // Step encoding picks the nibble pair: bit1 selects A half, bit0 B half,
    // so the order is lo*lo, lo*hi, hi*lo, hi*hi.
    assign w_nib_a = r_step[1] ? r_a[7:4] : r_a[3:0];
    assign w_nib_b = r_step[0] ? r_b[7:4] : r_b[3:0];

    Mult_Wallace4 u_mult (
        .a (w_nib_a),
        .b (w_nib_b),
        .p (w_pp)
    );

    always_comb begin
        w_pp_shifted = {8'd0, w_pp};
        case (r_step)
            2'd0:    w_pp_shifted = {8'd0, w_pp};
            2'd3:    w_pp_shifted = {w_pp, 8'd0};
            default: w_pp_shifted = {4'd0, w_pp, 4'd0};
        endcase
    end

    assign w_acc_next = r_acc + w_pp_shifted;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any)            w_state_next = c_ST_MUL;
            c_ST_MUL:  if (r_step == 2'd3)   w_state_next = c_ST_RESP;
            c_ST_RESP: if (rsp_ready)        w_state_next = c_ST_IDLE;
            default:                         w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = '0;
        if (r_state == c_ST_IDLE && w_any) begin
            req_ready[w_grant] = 1'b1;
        end
        busy = (r_state != c_ST_IDLE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_id   <= w_grant;
                        r_acc  <= '0;
                        r_step <= '0;
                        r_ptr  <= w_ptr_next;
                    end
                end
                c_ST_MUL: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_prod  <= w_acc_next;
                        r_rsp_id    <= r_id;
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_prod  = r_rsp_prod;

endmodule

// ============================================================================
// Module   : Mult_Wallace4
// Purpose  : Combinational 4x4 unsigned multiplier. Four shifted partial
//            product rows are reduced by two carry-save levels and resolved
//            by a final carry-propagate add.
// Ports    : a, b - 4-bit operands; p - 8-bit product
// Revision : 1.0 - initial release
// ============================================================================
module Mult_Wallace4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] w_row [4];
    logic [7:0] w_s1;
    logic [7:0] w_c1;
    logic [7:0] w_s2;
    logic [7:0] w_c2;

    for (genvar i = 0; i < 4; i++) begin : g_rows
        assign w_row[i] = {4'd0, a & {4{b[i]}}} << i;
    end

    // The product never exceeds 8 bits, so carries out of bit 6 are always
    // zero and the carry vectors only need bits [6:0] before the shift.
    assign w_s1 = w_row[0] ^ w_row[1] ^ w_row[2];
    assign w_c1 = {(w_row[0][6:0] & w_row[1][6:0]) |
                   (w_row[0][6:0] & w_row[2][6:0]) |
                   (w_row[1][6:0] & w_row[2][6:0]), 1'b0};

    assign w_s2 = w_s1 ^ w_c1 ^ w_row[3];
    assign w_c2 = {(w_s1[6:0] & w_c1[6:0]) |
                   (w_s1[6:0] & w_row[3][6:0]) |
                   (w_c1[6:0] & w_row[3][6:0]), 1'b0};

    assign p = w_s2 + w_c2;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_sched
// Purpose  : Self-checking bench for mult_share_sched. A cycle-level
//            reference model predicts grants, busy and response timing and
//            pushes the expected {id, A*B} into a scoreboard; a monitor
//            compares every presented response against the scoreboard head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_prod;
    logic           busy;

    mult_share_sched #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
    } job_t;

    exp_t sb[$];
    job_t jobs[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_mode = 1'b0;
    bit   rr_hold = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_job(input int id, input logic [7:0] a, input logic [7:0] b);
        job_t j;
        j.id = id;
        j.a  = a;
        j.b  = b;
        jobs.push_back(j);
    endtask

    // ---------------- Requester agent ----------------
    // Holds each request until its handshake, then drops valid and scrambles
    // its operands to FF/FF (the in-flight product must not change).
    initial begin : p_agent
        logic [N-1:0] g;
        logic [N-1:0] dropped;
        bit           found;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            g = rst ? '0 : (req_valid & req_ready);
            @(posedge clk);
            #1;
            dropped = '0;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    req_valid[i]    = 1'b0;
                    req_a[8*i +: 8] = 8'hFF;
                    req_b[8*i +: 8] = 8'hFF;
                    dropped[i]      = 1'b1;
                end else if (rand_mode && req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                    dropped[i]   = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && !dropped[i]) begin
                    found = 1'b0;
                    for (int j = 0; j < jobs.size(); j++) begin
                        if (!found && jobs[j].id == i) begin
                            req_a[8*i +: 8] = jobs[j].a;
                            req_b[8*i +: 8] = jobs[j].b;
                            req_valid[i]    = 1'b1;
                            jobs.delete(j);
                            found = 1'b1;
                        end
                    end
                    if (!found && rand_mode && $urandom_range(3) == 0) begin
                        req_a[8*i +: 8] = 8'($urandom);
                        req_b[8*i +: 8] = 8'($urandom);
                        req_valid[i]    = 1'b1;
                    end
                end
            end
            rsp_ready = rand_mode ? ($urandom_range(3) != 0) : rr_hold;
        end
    end

    // ---------------- Reference model / predictor ----------------
    // Accept at sample n; response visible from sample n+5; the block is
    // idle again on the sample after the response handshake.
    int m_ptr = 0;
    bit m_idle = 1'b1;
    int m_cnt = 0;
    bit m_after_rst = 1'b0;

    always @(negedge clk) begin : p_pred
        int          g;
        int          idx;
        exp_t        e;
        logic [15:0] pa;
        logic [15:0] pb;
        if (rst) begin
            m_idle      = 1'b1;
            m_ptr       = 0;
            m_cnt       = 0;
            m_after_rst = 1'b1;
            sb.delete();
        end else begin
            if (m_after_rst) begin
                check("reset_rsp_id", 32'(rsp_id), 32'd0);
                check("reset_rsp_prod", 32'(rsp_prod), 32'd0);
                m_after_rst = 1'b0;
            end
            if (m_idle) begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                check("grant_req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    pa     = 16'(req_a[8*g +: 8]);
                    pb     = 16'(req_b[8*g +: 8]);
                    e.id   = 2'(g);
                    e.prod = pa * pb;
                    sb.push_back(e);
                    m_ptr  = (g + 1) % N;
                    m_idle = 1'b0;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt++;
                check("active_busy", 32'(busy), 32'd1);
                check("active_req_ready", 32'(req_ready), 32'd0);
                check("rsp_valid_timing", 32'(rsp_valid), (m_cnt >= 5) ? 32'd1 : 32'd0);
                if (m_cnt >= 5 && rsp_ready) m_idle = 1'b1;
            end
        end
    end

    // ---------------- Response monitor ----------------
    always @(negedge clk) begin : p_mon
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                check("rsp_prod", 32'(rsp_prod), 32'(sb[0].prod));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (n < lim && !(jobs.size() == 0 && req_valid == '0 && !busy &&
                            !rsp_valid && sb.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", {27'd0, req_valid, busy}, 32'd0);
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single zero-operand request, then FF*FF on requester 2
        add_job(0, 8'h00, 8'h00);
        wait_done(100);
        add_job(2, 8'hFF, 8'hFF);
        wait_done(100);

        // all four valid continuously, pointer back at 0 after reset
        do_reset();
        add_job(0, 8'h12, 8'h34);
        add_job(1, 8'hAB, 8'h01);
        add_job(2, 8'h80, 8'h02);
        add_job(3, 8'h0F, 8'hF0);
        add_job(0, 8'h12, 8'h34);
        wait_done(300);

        // back-pressure with requester 1 waiting
        rr_hold = 1'b0;
        add_job(0, 8'h07, 8'h09);
        n = 0;
        while (n < 50 && !(jobs.size() == 0 && req_valid == '0 && busy)) begin
            @(negedge clk);
            n++;
        end
        add_job(1, 8'h03, 8'h05);
        repeat (10) @(posedge clk);
        #1 rr_hold = 1'b1;
        wait_done(100);

        // operand change after accept (agent scrambles to FF/FF)
        add_job(2, 8'h10, 8'h10);
        wait_done(100);

        // reset during MUL step k2
        add_job(1, 8'h55, 8'h66);
        n = 0;
        while (n < 50 && !(req_valid[1] && req_ready[1])) begin
            @(negedge clk);
            n++;
        end
        check("abort_grant_seen", 32'(req_valid[1] && req_ready[1]), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        add_job(3, 8'h21, 8'h43);
        wait_done(100);

        // randomized traffic with random back-pressure
        rand_mode = 1'b1;
        repeat (3000) @(posedge clk);
        #1 rand_mode = 1'b0;
        wait_done(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Scheduler that shares a single 4x4 unsigned multiplier (Mult_Wallace4, instantiated inside this block) among NUM_REQ requesters.
- Each requester submits an 8x8 unsigned multiply. The block grants requests round-robin and sequences four nibble partial products through the multiplier.
- It accumulates the partial products into a 16-bit product and returns the product with the requester ID over a valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand B; same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_prod  output  16  unsigned product A*B.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State goes to IDLE.
  - req_ready=0 (combinational, from IDLE only), rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0.
  - Round-robin pointer ptr=0, step counter=0, accumulator=0.
- Reset mid-operation discards the in-flight multiply and any pending response; no response is ever emitted for it.
- States: IDLE, MUL, RESP.
- IDLE:
  - Grant g = first index with req_valid set, searching ptr, ptr+1, ... with wrap mod NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - If no requester is valid, req_ready=0 and the block stays in IDLE.
  - On the handshake edge:
    - capture A, B and id=g;
    - clear accumulator and step counter;
    - ptr <= (g+1) mod NUM_REQ;
    - go to MUL.
- MUL: one partial product per cycle, step k=0..3, acc <= acc + (nibble product << shift):
  - k0: A[3:0]*B[3:0], shift 0.
  - k1: A[3:0]*B[7:4], shift 4.
  - k2: A[7:4]*B[3:0], shift 4.
  - k3: A[7:4]*B[7:4], shift 8.
  - Accumulator is 16 bits and never overflows (max 0xFE01).
  - After k3 go to RESP; rsp_prod is loaded with the final sum.
- Latency:
  - Handshake edge E0; MUL occupies edges E1..E4; rsp_valid rises after E4.
  - That is 4 cycles from accept to valid.
  - Minimum request-to-request spacing is 6 cycles (accept, 4 MUL, 1 RESP with rsp_ready=1).
- RESP:
  - rsp_valid=1; rsp_id and rsp_prod are held stable until the edge where rsp_ready=1.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - rsp_prod and rsp_id keep their last values after the handshake.
  - No new request is accepted in RESP; the next accept occurs in IDLE at the earliest one cycle after the response handshake.
- Requesters must hold req_valid, req_a and req_b stable until their req_ready is seen. Operands are sampled only on the handshake edge; later changes do not affect the in-flight product.
- A requester that drops req_valid before being granted loses its turn; no state is kept for it.
- Back-pressure: rsp_ready held low keeps the block in RESP indefinitely. Requests wait with req_ready=0.
- Operands of zero are processed normally (4 MUL cycles, product 0).

Test Plan:
- Reset then single request: req 0, A=0x00, B=0x00 -> req_ready[0] high in the same cycle; rsp_valid 4 cycles after accept; rsp_id=0, rsp_prod=0x0000.
- Single request: req 2, A=0xFF, B=0xFF, rsp_ready=1 -> rsp_prod=0xFE01, rsp_id=2, rsp_valid high for exactly 1 cycle.
- All four requesters valid continuously with distinct operands:
  - Operands: (0x12,0x34), (0xAB,0x01), (0x80,0x02), (0x0F,0xF0).
  - Required grant order 0,1,2,3,0 with products 0x03A8, 0x00AB, 0x0100, 0x0E10.
  - Required accepts spaced 6 cycles apart.
- Back-pressure: A=0x07, B=0x09, rsp_ready=0 for 10 cycles, requester 1 also valid:
  - rsp_valid stays high with rsp_prod=0x003F held stable;
  - req_ready stays 0;
  - after rsp_ready=1, requester 1 is granted one cycle after the response handshake.
- Operand change after accept: A=0x10, B=0x10 accepted, then inputs changed to 0xFF/0xFF -> rsp_prod=0x0100.
- Reset asserted during MUL step k2 -> next cycle busy=0, rsp_valid=0, ptr=0; no response for the aborted op; a new request from requester 3 is then served normally.
